// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy states, reset PC
// and the ID/EX decoded-control field set with pack/unpack helpers.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam logic [63:0] PC_RST_DEFAULT = 64'h8000_0000;

    // Field set carried across the ID/EX boundary; padded to a 256-bit payload.
    typedef struct packed {
        logic [38:0] rsvd;
        logic        branch;
        logic        jump;
        logic        reg_wen;
        logic [4:0]  waddr;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
        logic [63:0] imm;
        logic [4:0]  alu_op;
        logic [1:0]  alu_src;
        logic [7:0]  wmask;
        logic        load_signed;
        logic        load_unsigned;
    } id_ex_payload_t;

    localparam int ID_EX_PAYLOAD_W = $bits(id_ex_payload_t);

    function automatic logic [ID_EX_PAYLOAD_W-1:0] pack_id_ex(input id_ex_payload_t f);
        id_ex_payload_t t;
        t      = f;
        t.rsvd = '0;
        return t;
    endfunction

    function automatic id_ex_payload_t unpack_id_ex(input logic [ID_EX_PAYLOAD_W-1:0] v);
        return id_ex_payload_t'(v);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX stage register with valid/ready handshake, flush, optional two-entry
// skid buffer (registered ready) and saturating stall/bubble counters.
module id_ex_pipe_stage
    import pipe_pkg::*;
#(
    parameter int              PC_W      = 64,
    parameter int              PAYLOAD_W = 256,
    parameter logic [PC_W-1:0] PC_RST    = PC_W'(PC_RST_DEFAULT),
    parameter int              SKID      = 1,
    parameter int              CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PC_W-1:0]      in_pc_i,
    input  logic [PAYLOAD_W-1:0] in_payload_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PC_W-1:0]      out_pc_o,
    output logic [PAYLOAD_W-1:0] out_payload_o,
    input  logic                 cnt_clr_i,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     bubble_cnt_o
);

    logic w_out_valid;
    logic w_in_ready;

    if (SKID != 0) begin : g_skid
        pipe_state_e          r_state;
        pipe_state_e          w_state_nxt;
        logic                 r_in_ready;
        logic [PC_W-1:0]      r_m_pc;
        logic [PC_W-1:0]      r_s_pc;
        logic [PAYLOAD_W-1:0] r_m_pl;
        logic [PAYLOAD_W-1:0] r_s_pl;
        logic                 w_in_fire;
        logic                 w_out_fire;
        logic                 w_ld_m_in;
        logic                 w_ld_m_s;
        logic                 w_ld_s;

        assign w_in_fire  = in_valid_i & r_in_ready;
        assign w_out_fire = (r_state != EMPTY) & out_ready_i;

        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        always_comb begin
            w_state_nxt = r_state;
            w_ld_m_in   = 1'b0;
            w_ld_m_s    = 1'b0;
            w_ld_s      = 1'b0;
            unique case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_ld_m_in   = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_ld_m_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_ld_s      = 1'b1;
                        w_state_nxt = FULL;
                    end else if (w_out_fire) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_ld_m_s    = 1'b1;
                        w_state_nxt = ONE;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
            // Redirect discards everything in flight; data registers simply hold.
            if (flush_i) begin
                w_state_nxt = EMPTY;
                w_ld_m_in   = 1'b0;
                w_ld_m_s    = 1'b0;
                w_ld_s      = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state    <= EMPTY;
                r_in_ready <= 1'b1;
            end else begin
                r_state    <= w_state_nxt;
                r_in_ready <= (w_state_nxt != FULL);
            end
        end

        // NOTE: the wide data registers are reset only because a defined post-reset PC is visible.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_m_pc <= PC_RST;
                r_m_pl <= '0;
                r_s_pc <= '0;
                r_s_pl <= '0;
            end else begin
                if (w_ld_m_in) begin
                    r_m_pc <= in_pc_i;
                    r_m_pl <= in_payload_i;
                end else if (w_ld_m_s) begin
                    r_m_pc <= r_s_pc;
                    r_m_pl <= r_s_pl;
                end
                if (w_ld_s) begin
                    r_s_pc <= in_pc_i;
                    r_s_pl <= in_payload_i;
                end
            end
        end

        assign w_out_valid   = (r_state != EMPTY);
        assign w_in_ready    = r_in_ready;
        assign out_pc_o      = r_m_pc;
        assign out_payload_o = r_m_pl;
    end else begin : g_single
        logic                 r_valid;
        logic [PC_W-1:0]      r_m_pc;
        logic [PAYLOAD_W-1:0] r_m_pl;
        logic                 w_in_fire;
        logic                 w_out_fire;

        assign w_in_ready = ~r_valid | out_ready_i;
        assign w_in_fire  = in_valid_i & w_in_ready;
        assign w_out_fire = r_valid & out_ready_i;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_m_pc  <= PC_RST;
                r_m_pl  <= '0;
            end else if (flush_i) begin
                r_valid <= 1'b0;
            end else begin
                if (w_in_fire) begin
                    r_valid <= 1'b1;
                    r_m_pc  <= in_pc_i;
                    r_m_pl  <= in_payload_i;
                end else if (w_out_fire) begin
                    r_valid <= 1'b0;
                end
            end
        end

        assign w_out_valid   = r_valid;
        assign out_pc_o      = r_m_pc;
        assign out_payload_o = r_m_pl;
    end

    assign out_valid_o = w_out_valid;
    assign in_ready_o  = w_in_ready;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (w_out_valid & ~out_ready_i),
        .clr_i (cnt_clr_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (~w_out_valid),
        .clr_i (cnt_clr_i),
        .cnt_o (bubble_cnt_o)
    );

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Random and directed stimulus for three configurations of id_ex_pipe_stage,
// checked each cycle against queue-based FIFO and counter reference models.
module tb_id_ex_pipe_stage;

    localparam logic [63:0] PC_RST_EXP = 64'h8000_0000;
    localparam longint unsigned MAX32 = 64'hFFFF_FFFF;
    localparam longint unsigned MAX4  = 64'd15;

    typedef struct packed {
        logic [63:0]  pc;
        logic [255:0] pl;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic         cnt_clr;
    logic [63:0]  in_pc;
    logic [255:0] in_pl;

    logic         rdy1, vld1, rdy0, vld0, rdy4, vld4;
    logic [63:0]  pc1, pc0, pc4;
    logic [255:0] pl1, pl0, pl4;
    logic [31:0]  st1, bb1, st0, bb0;
    logic [3:0]   st4, bb4;

    ent_t q1[$];
    ent_t q0[$];
    longint unsigned st1_m, bb1_m, st0_m, bb0_m, st4_m, bb4_m;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_pipe_stage #(.SKID(1)) u_dut_skid (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy1),
        .in_pc_i(in_pc), .in_payload_i(in_pl), .out_valid_o(vld1), .out_ready_i(out_ready),
        .out_pc_o(pc1), .out_payload_o(pl1), .cnt_clr_i(cnt_clr),
        .stall_cnt_o(st1), .bubble_cnt_o(bb1)
    );

    id_ex_pipe_stage #(.SKID(0)) u_dut_single (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy0),
        .in_pc_i(in_pc), .in_payload_i(in_pl), .out_valid_o(vld0), .out_ready_i(out_ready),
        .out_pc_o(pc0), .out_payload_o(pl0), .cnt_clr_i(cnt_clr),
        .stall_cnt_o(st0), .bubble_cnt_o(bb0)
    );

    id_ex_pipe_stage #(.SKID(1), .CNT_W(4)) u_dut_cnt4 (
        .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy4),
        .in_pc_i(in_pc), .in_payload_i(in_pl), .out_valid_o(vld4), .out_ready_i(out_ready),
        .out_pc_o(pc4), .out_payload_o(pl4), .cnt_clr_i(cnt_clr),
        .stall_cnt_o(st4), .bubble_cnt_o(bb4)
    );

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic longint unsigned sat_inc(input longint unsigned v, input longint unsigned max);
        return (v < max) ? v + 1 : v;
    endfunction

    task automatic drive(input logic v, input logic [63:0] pc, input logic ordy,
                         input logic fl, input logic clr);
        in_valid  = v;
        in_pc     = pc;
        in_pl     = rand256();
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
    endtask

    task automatic compare();
        check("in_ready_skid", rdy1, q1.size() < 2);
        check("out_valid_skid", vld1, q1.size() != 0);
        if (q1.size() != 0) begin
            check("out_pc_skid", pc1, q1[0].pc);
            check("out_pl_skid", pl1, q1[0].pl);
        end
        check("stall_skid", st1, st1_m);
        check("bubble_skid", bb1, bb1_m);

        check("in_ready_single", rdy0, (q0.size() == 0) || out_ready);
        check("out_valid_single", vld0, q0.size() != 0);
        if (q0.size() != 0) begin
            check("out_pc_single", pc0, q0[0].pc);
            check("out_pl_single", pl0, q0[0].pl);
        end
        check("stall_single", st0, st0_m);
        check("bubble_single", bb0, bb0_m);

        check("out_valid_cnt4", vld4, q1.size() != 0);
        if (q1.size() != 0) check("out_pc_cnt4", pc4, q1[0].pc);
        check("stall_cnt4", st4, st4_m);
        check("bubble_cnt4", bb4, bb4_m);
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        bit   v1, v0, f1_in, f1_out, f0_in, f0_out;
        ent_t e;
        #1;
        compare();
        v1     = (q1.size() != 0);
        v0     = (q0.size() != 0);
        f1_in  = in_valid && (q1.size() < 2);
        f1_out = v1 && out_ready;
        f0_in  = in_valid && (!v0 || out_ready);
        f0_out = v0 && out_ready;
        e.pc   = in_pc;
        e.pl   = in_pl;
        @(posedge clk);
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (f1_out) void'(q1.pop_front());
            if (f1_in)  q1.push_back(e);
            if (f0_out) void'(q0.pop_front());
            if (f0_in)  q0.push_back(e);
        end
        if (cnt_clr) begin
            st1_m = 0; bb1_m = 0; st0_m = 0; bb0_m = 0; st4_m = 0; bb4_m = 0;
        end else begin
            if (v1 && !out_ready) begin
                st1_m = sat_inc(st1_m, MAX32);
                st4_m = sat_inc(st4_m, MAX4);
            end
            if (!v1) begin
                bb1_m = sat_inc(bb1_m, MAX32);
                bb4_m = sat_inc(bb4_m, MAX4);
            end
            if (v0 && !out_ready) st0_m = sat_inc(st0_m, MAX32);
            if (!v0)              bb0_m = sat_inc(bb0_m, MAX32);
        end
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid_skid"}, vld1, 1'b0);
        check({tag, "_pc_skid"}, pc1, PC_RST_EXP);
        check({tag, "_pl_skid"}, pl1, 256'd0);
        check({tag, "_ready_skid"}, rdy1, 1'b1);
        check({tag, "_cnt_skid"}, {st1, bb1}, 64'd0);
        check({tag, "_valid_single"}, vld0, 1'b0);
        check({tag, "_pc_single"}, pc0, PC_RST_EXP);
        check({tag, "_ready_single"}, rdy0, 1'b1);
        check({tag, "_cnt_single"}, {st0, bb0}, 64'd0);
        check({tag, "_valid_cnt4"}, vld4, 1'b0);
        check({tag, "_cnt_cnt4"}, {st4, bb4}, 8'd0);
    endtask

    // Asserts reset between edges and checks the outputs before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_reset("rst_async");
        @(posedge clk);
        #1;
        check_reset("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        q1.delete();
        q0.delete();
        st1_m = 0; bb1_m = 0; st0_m = 0; bb0_m = 0; st4_m = 0; bb4_m = 0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        st1_m = 0; bb1_m = 0; st0_m = 0; bb0_m = 0; st4_m = 0; bb4_m = 0;
        #2;
        check_reset("por");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle long enough to saturate the 4-bit bubble counter, then clear.
        repeat (20) begin
            drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
            cycle();
        end
        check("bubble_cnt4_sat", bb4, 4'd15);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b1);
        cycle();
        check("bubble_cnt4_clr", bb4, 4'd0);

        // Streaming at full rate.
        drive(1'b1, 64'h100, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h104, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h108, 1'b1, 1'b0, 1'b0); cycle();
        repeat (3) begin
            drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
            cycle();
        end

        // Backpressure: fill the skid buffer, hold 0x208 off, then release.
        drive(1'b1, 64'h200, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h204, 1'b0, 1'b0, 1'b0); cycle();
        repeat (3) begin
            drive(1'b1, 64'h208, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        check("full_ready_low", rdy1, 1'b0);
        drive(1'b1, 64'h208, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h208, 1'b1, 1'b0, 1'b0); cycle();
        repeat (4) begin
            drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
            cycle();
        end

        // Flush while full with a simultaneous input that must never appear.
        drive(1'b1, 64'h2f0, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h2f4, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h300, 1'b1, 1'b1, 1'b0); cycle();
        check("flush_valid_skid", vld1, 1'b0);
        repeat (3) begin
            drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
            cycle();
        end

        // Ready toggling 1,0,1 against the single-register variant.
        drive(1'b1, 64'h400, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h404, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h408, 1'b1, 1'b0, 1'b0); cycle();
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0); cycle();

        // Reset mid-stream with entries buffered.
        drive(1'b1, 64'h500, 1'b0, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h504, 1'b0, 1'b0, 1'b0); cycle();
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom},
                  $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 63) == 0);
            cycle();
            if (i == 1500) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_stage.md
# id_ex_pipe_stage

Parametrised ID/EX pipeline stage register with a valid/ready handshake, synchronous flush, an optional two-entry skid buffer and saturating stall/bubble counters. It sits between the decoder and the execute unit. It carries the instruction PC plus an opaque decoded-control payload, so the same block can be reused for other stage boundaries. It adds backpressure, stage-local flush and in-order buffering, none of which the plain always-load stage register provides.

## Interface
Parameters:
- `PC_W`, 64, PC width
- `PAYLOAD_W`, 256, packed decoded-control/operand payload width
- `PC_RST`, 64'h8000_0000, reset value of `out_pc_o`
- `SKID`, 1, 1 = two-entry skid buffer with registered `in_ready_o`; 0 = single register
- `CNT_W`, 32, width of the performance counters

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `flush_i` in 1: synchronous flush (branch/jump redirect)
- `in_valid_i` in 1: decoder has an instruction
- `in_ready_o` out 1: stage can accept
- `in_pc_i` in PC_W: instruction PC
- `in_payload_i` in PAYLOAD_W: decoded payload
- `out_valid_o` out 1: execute-side instruction valid
- `out_ready_i` in 1: execute accepts
- `out_pc_o` out PC_W: registered PC
- `out_payload_o` out PAYLOAD_W: registered payload
- `cnt_clr_i` in 1: synchronous clear of both counters
- `stall_cnt_o` out CNT_W: cycles with out_valid_o=1 and out_ready_i=0
- `bubble_cnt_o` out CNT_W: cycles with out_valid_o=0

## Operation
- Handshake rules:
  - Input fire = `in_valid_i & in_ready_o`.
  - Output fire = `out_valid_o & out_ready_i`.
  - Data is strictly FIFO. No entry is dropped or duplicated except by flush.
- SKID=1 uses an occupancy FSM with main register M (drives the outputs) and skid register S:
  - EMPTY: in fire → M←in, go to ONE.
  - ONE: in fire & out fire → M←in, stay in ONE. In fire only → S←in, go to FULL. Out fire only → EMPTY.
  - FULL: out fire → M←S, go to ONE. In_valid is ignored in FULL.
  - `in_ready_o` = (state != FULL). It is driven from a register, with no combinational path from `out_ready_i`.
- SKID=0:
  - Single register M.
  - `in_ready_o = !out_valid_o | out_ready_i` (combinational).
  - Load on in fire.
  - No FSM beyond the valid bit.
- Flush:
  - Highest priority after reset.
  - Next state is EMPTY and `out_valid_o`←0.
  - An in fire in the same cycle is discarded.
  - PC and payload registers hold their values; they are don't-care while invalid.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at 2^CNT_W−1, with no wrap.
  - `cnt_clr_i` sets both counters to 0 and overrides that cycle's increment.
  - `rst` does not gate counting after release.

## Timing
- Reset values:
  - `out_valid_o`=0, `out_pc_o`=PC_RST, `out_payload_o`=0.
  - `in_ready_o`=1 (EMPTY).
  - S cleared.
  - Both counters 0.
  - State EMPTY.
- Reset mid-operation: everything returns to the reset values immediately, asynchronously. Buffered entries are lost.
- Latency: an instruction accepted at edge N is visible on the outputs after edge N, when it enters M directly. An instruction parked in S appears one edge after M drains.
- Throughput: one instruction per cycle sustained while `out_ready_i`=1.
- SKID=1: at most two entries in flight. `in_ready_o` deasserts the cycle after FULL is entered.
- Simultaneous events:
  - `flush_i` together with a FULL drain → EMPTY; S is not promoted.
  - `cnt_clr_i` together with saturation → 0.

## Structure
- Shared package `pipe_pkg` holds:
  - The `pipe_state_e` enum (EMPTY, ONE, FULL).
  - The `PC_RST_DEFAULT` constant.
  - A payload packing helper struct for the ID/EX field set: branch, jump, reg_wen, waddr, rs1/rs2 data, imm, alu_op, alu_src, wmask, load-sign flags.
- One sub-module, `sat_counter` (parameter W, with inc and clr inputs), instantiated twice.

## Test plan
- Reset with `rst`=1 mid-stream: `out_valid_o`=0, `out_pc_o`=0x8000_0000, `in_ready_o`=1, counters 0 within the same cycle.
- SKID=1 streaming with PCs 0x100, 0x104, 0x108 and `out_ready_i`=1: outputs appear one per cycle in order, `bubble_cnt_o` stops incrementing.
- SKID=1 backpressure: `out_ready_i`=0 while sending 0x200 and 0x204 → FULL, `in_ready_o`=0, 0x208 held off. Release → 0x200, 0x204, 0x208 in order; `stall_cnt_o` equals the stalled cycles.
- Flush while FULL with a simultaneous input 0x300: next cycle `out_valid_o`=0, state EMPTY, and 0x300 never emitted.
- SKID=0 with `out_ready_i` toggling 1,0,1: `in_ready_o` follows `!out_valid_o | out_ready_i` combinationally, with no loss or duplication.
- CNT_W=4 with 20 bubble cycles: `bubble_cnt_o` saturates at 15. Then `cnt_clr_i` → 0.
